key_switch_debounce: RTL and testbench



---
 rtl/deca_io_pkg.sv | 17 +
 rtl/debounce_chan.sv | 72 +++++++
 rtl/key_switch_debounce.sv | 55 +++++
 tb/tb_key_switch_debounce.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/deca_io_pkg.sv
// Shared constants and helpers for the DECA board I/O conditioning blocks.
// Channel layout of the button/switch vector and counter sizing.
package deca_io_pkg;

    localparam int KEY_LSB = 0;
    localparam int SW_LSB  = 2;
    localparam int N_KEY   = 2;
    localparam int N_SW    = 2;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int clog2_min1(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One input channel: polarity fix, 2-flop synchroniser, stability counter,
// debounced level and one-cycle rise/fall pulses.
module debounce_chan
    import deca_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit INVERT          = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg,  sync1_next;
    logic          sync2_reg,  sync2_next;
    logic          stable_reg, stable_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic          rise_reg,   rise_next;
    logic          fall_reg,   fall_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            sync1_reg  <= sync1_next;
            sync2_reg  <= sync2_next;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    always_comb begin
        sync1_next  = raw ^ INVERT;
        sync2_next  = sync1_reg;
        stable_next = stable_reg;
        cnt_next    = cnt_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        accept      = 1'b0;
        // Any re-match with the accepted level throws away the partial count.
        if (sync2_reg == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == TERM_CNT) begin
            stable_next = sync2_reg;
            cnt_next    = '0;
            rise_next   = sync2_reg;
            fall_next   = ~sync2_reg;
            accept      = 1'b1;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    assign level = stable_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/key_switch_debounce.sv
// Debounces the DECA KEY/SW pins into clean levels, edge pulses and sticky
// per-channel event flags for the button/switch PIOs.
module key_switch_debounce
    import deca_io_pkg::*;
#(
    parameter int              N_IN            = 4,
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter logic [N_IN-1:0] INVERT_MASK     = {N_IN{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level_out,
    output logic [N_IN-1:0] rise_pulse,
    output logic [N_IN-1:0] fall_pulse,
    output logic [N_IN-1:0] event_pending,
    input  logic [N_IN-1:0] event_clr
);

    logic [N_IN-1:0] accept;
    logic [N_IN-1:0] event_pending_reg, event_pending_next;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
            debounce_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (INVERT_MASK[gi])
            ) u_chan (
                .clk    (clk),
                .reset  (reset),
                .raw    (raw_in[gi]),
                .level  (level_out[gi]),
                .rise   (rise_pulse[gi]),
                .fall   (fall_pulse[gi]),
                .accept (accept[gi])
            );
        end
    endgenerate

    // A new accepted edge outranks a clear landing in the same cycle.
    always_comb begin
        event_pending_next = (event_pending_reg & ~event_clr) | accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_pending_reg <= '0;
        end else begin
            event_pending_reg <= event_pending_next;
        end
    end

    assign event_pending = event_pending_reg;

endmodule

// File: tb/tb_key_switch_debounce.sv
// Randomised scoreboard bench for key_switch_debounce with a sample-window
// reference model: an edge is accepted after DEBOUNCE_CYCLES differing samples.
module tb_key_switch_debounce;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] event_clr;
    logic [N-1:0] level_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic [N-1:0] event_pending;

    key_switch_debounce #(
        .N_IN            (N),
        .DEBOUNCE_CYCLES (D),
        .INVERT_MASK     (4'b1111)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_in        (raw_in),
        .level_out     (level_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .event_pending (event_pending),
        .event_clr     (event_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   started  = 1'b0;

    // Reference: pin values pass through two sample delays; a channel flips
    // once its last D delayed samples all disagree with the accepted level.
    logic [N-1:0] m_d1, m_d2, m_stable, m_pend;
    bit           hist[N][$];

    always @(posedge clk) begin : model
        logic [N-1:0] rise, fall;
        exp_t         e;
        bit           all_diff;
        started = 1'b1;
        cyc++;
        rise = '0;
        fall = '0;
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0; m_pend = '0;
            for (int c = 0; c < N; c++) hist[c].delete();
        end else begin
            for (int c = 0; c < N; c++) begin
                hist[c].push_back(m_d2[c]);
                if (hist[c].size() > D) void'(hist[c].pop_front());
                all_diff = (hist[c].size() == D);
                foreach (hist[c][j]) if (hist[c][j] == m_stable[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable[c] = ~m_stable[c];
                    rise[c] = m_stable[c];
                    fall[c] = ~m_stable[c];
                end
            end
            m_pend = (m_pend & ~event_clr) | rise | fall;
            m_d2 = m_d1;
            m_d1 = ~raw_in;
        end
        e.level = m_stable;
        e.rise  = rise;
        e.fall  = fall;
        e.pend  = m_pend;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e, a;
        if (started) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cycle=%0d: no expected entry", cyc);
            end else begin
                e = exp_q.pop_front();
                a = {level_out, rise_pulse, fall_pulse, event_pending};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle=%0d: got lvl=%h rise=%h fall=%h pend=%h, expected lvl=%h rise=%h fall=%h pend=%h",
                             cyc, a.level, a.rise, a.fall, a.pend, e.level, e.rise, e.fall, e.pend);
                end else begin
                    $display("cycle=%0d raw=%h clr=%h rst=%0d lvl=%h rise=%h fall=%h pend=%h ok",
                             cyc, raw_in, event_clr, reset, a.level, a.rise, a.fall, a.pend);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] flip;
        reset     = 1'b1;
        raw_in    = 4'hF;
        event_clr = '0;
        step(3);
        reset = 1'b0;
        step(20);

        // Press KEY0, then a bouncing KEY1 that never settles long enough.
        raw_in[0] = 1'b0;
        step(10);
        for (int r = 0; r < 4; r++) begin
            raw_in[1] = 1'b0; step(3);
            raw_in[1] = 1'b1; step(3);
        end

        // Release KEY0.
        raw_in[0] = 1'b1;
        step(10);

        // Press again with a clear coinciding with the accept cycle, then clear.
        event_clr[0] = 1'b1; step(1);
        event_clr[0] = 1'b0;
        raw_in[0] = 1'b0;
        step(5);
        event_clr[0] = 1'b1; step(2);
        event_clr[0] = 1'b0;
        step(4);

        // Reset in the middle of debouncing channel 3.
        raw_in[3] = 1'b0;
        step(4);
        reset = 1'b1; step(1);
        reset = 1'b0;
        step(12);

        // Alternating noisy and quiet random segments.
        for (int seg = 0; seg < 12; seg++) begin
            for (int t = 0; t < 60; t++) begin
                for (int c = 0; c < N; c++)
                    flip[c] = ($urandom_range(0, (seg % 2) ? 2 : 11) == 0);
                raw_in    = raw_in ^ flip;
                event_clr = N'($urandom) & N'($urandom) & N'($urandom);
                reset     = ($urandom_range(0, 199) == 0);
                step(1);
            end
        end
        reset     = 1'b0;
        event_clr = '0;
        step(3);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
